// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the divider.
interface div_unit_if;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] result;
  logic        busy;
  logic        done;
  modport master (output start, flush, op, data1, data2, input result, busy, done);
  modport slave  (input start, flush, op, data1, data2, output result, busy, done);
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU.
module div_unit (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2;
  logic [1:0]  state, op_q;
  logic [31:0] rem, quo, dvs, spec_res, result_q;
  logic        q_neg, r_neg, special, done_q;
  logic [4:0]  cnt;
  logic        sgn, s1, s2, zero, ovf, ge, neg;
  logic [31:0] abs1, abs2, diff, val;
  logic [32:0] shifted;
  always_comb begin
    sgn     = !bus.op[0];
    s1      = sgn & bus.data1[31];
    s2      = sgn & bus.data2[31];
    abs1    = s1 ? -bus.data1 : bus.data1;
    abs2    = s2 ? -bus.data2 : bus.data2;
    zero    = bus.data2 == 32'd0;
    ovf     = sgn && bus.data1 == 32'h8000_0000 && bus.data2 == 32'hFFFF_FFFF;
    shifted = {rem, quo[31]};
    ge      = shifted >= {1'b0, dvs};
    diff    = shifted[31:0] - dvs;
    val     = op_q[1] ? rem : quo;
    neg     = op_q[1] ? r_neg : q_neg;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= 2'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvs      <= 32'd0;
      spec_res <= 32'd0;
      result_q <= 32'd0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      special  <= 1'b0;
      done_q   <= 1'b0;
      cnt      <= 5'd0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) state <= IDLE;
      else case (state)
        IDLE: if (bus.start) begin
          op_q     <= bus.op;
          rem      <= 32'd0;
          quo      <= abs1;
          dvs      <= abs2;
          q_neg    <= s1 ^ s2;
          r_neg    <= s1;
          cnt      <= 5'd0;
          special  <= zero | ovf;
          // divide-by-zero wins over overflow: the divisor is zero, not -1
          spec_res <= zero ? (bus.op[1] ? bus.data1 : 32'hFFFF_FFFF)
                           : (bus.op[1] ? 32'd0 : 32'h8000_0000);
          state    <= (zero | ovf) ? FINISH : CALC;
        end
        CALC: begin
          rem   <= ge ? diff : shifted[31:0];
          quo   <= {quo[30:0], ge};
          cnt   <= cnt + 5'd1;
          state <= (cnt == 5'd31) ? FINISH : CALC;
        end
        FINISH: begin
          result_q <= special ? spec_res : (neg ? -val : val);
          done_q   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = state != IDLE;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit covering results, latency, flush and reset.
module tb_div_unit;
  logic clk, rst_n;
  div_unit_if bus ();
  div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_checks = 0, n_fail = 0;
  logic [31:0] sb[$];
  logic [31:0] last_exp = 32'd0;
  logic prev_done = 1'b0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'd0: return $signed(a) / $signed(b);
      2'd1: return a / b;
      2'd2: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction
  always @(negedge clk) begin
    if (bus.done) begin
      check("done_pulse", {31'd0, prev_done}, 32'd0);
      check("pending", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        last_exp = sb.pop_front();
        check("result", bus.result, last_exp);
      end
    end
    prev_done = bus.done;
  end
  // Called at a negedge; START is sampled at the following rising edge (cycle 0).
  task automatic op_run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int fl);
    int n, bcnt;
    bus.op = o; bus.data1 = a; bus.data2 = b; bus.start = 1'b1;
    if (fl == 0) sb.push_back(exp);
    @(posedge clk); #1 bus.start = 1'b0;
    bcnt = 0;
    for (n = 1; n <= lat + 2; n++) begin
      @(negedge clk);
      if (fl != 0 && n == fl + 1) begin
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_result", bus.result, last_exp);
        break;
      end
      if (bus.done) break;
      bcnt += int'(bus.busy);
      if (n == 5 || n == 20) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.data1 = 32'h1234; bus.data2 = 32'd1;
      end
      if (n == fl) bus.flush = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
    end
    if (fl == 0) begin
      check("latency", n, lat);
      check("busy_cycles", bcnt, lat - 1);
      check("busy_at_done", {31'd0, bus.busy}, 32'd0);
    end
  endtask
  initial begin
    logic [31:0] a, b;
    logic [1:0] o;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'd0; bus.data1 = 32'd0; bus.data2 = 32'd0;
    #12;
    check("rst_result", bus.result, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    op_run(2'd0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 0);
    op_run(2'd2, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 34, 0);
    op_run(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    op_run(2'd1, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34, 0);
    op_run(2'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 34, 0);
    op_run(2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 0);
    op_run(2'd3, 32'd5, 32'd0, 32'h0000_0005, 2, 0);
    op_run(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
    op_run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 0);
    op_run(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
    for (int i = 0; i < 6; i++) begin
      o = 2'(i);
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd3;
      if (b == 32'hFFFF_FFFF) b = 32'd5;
      op_run(o, a, b, model(o, a, b), 34, 0);
    end
    @(negedge clk);
    op_run(2'd0, 32'd1000, 32'd3, 32'd0, 34, 10);
    @(negedge clk);
    op_run(2'd1, 32'd1000, 32'd3, 32'd333, 34, 0);
    @(negedge clk);
    bus.op = 2'd1; bus.data1 = 32'd100; bus.data2 = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (15) @(negedge clk);
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_result", bus.result, 32'd0);
    check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("async_rst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    op_run(2'd1, 32'd7, 32'd3, 32'd2, 34, 0);
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
